// File: rtl/wb_accel_initiator.sv
// Single-outstanding classic Wishbone initiator for the accelerator slave port.
// One command in, one bus cycle, one response out; a timeout aborts a silent slave.
module wb_accel_initiator #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 8
) (
   input  logic              wishbone_clk_i,
   input  logic              wishbone_rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              wishbone_cyc_o,
   output logic              wishbone_stb_o,
   output logic              wishbone_we_o,
   output logic [ADDR_W-1:0] wishbone_addr_o,
   output logic [DATA_W-1:0] wishbone_data_o,
   input  logic [DATA_W-1:0] wishbone_data_i,
   input  logic              wishbone_ack_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT - 1);

   state_t            r_state;
   state_t            w_nextState;
   logic              r_outOfReset;
   logic              r_cyc;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rspValid;
   logic              r_rspErr;
   logic [DATA_W-1:0] r_rspData;
   logic [TO_W-1:0]   r_toCnt;
   logic              w_accept;
   logic              w_timeout;

   assign cmd_ready_o     = (r_state == IDLE) && r_outOfReset;
   assign w_accept        = cmd_valid_i && cmd_ready_o;
   assign w_timeout       = (TIMEOUT != 0) && (r_toCnt == LAST_CNT);
   assign busy_o          = (r_state != IDLE);
   assign wishbone_cyc_o  = r_cyc;
   assign wishbone_stb_o  = r_cyc;
   assign wishbone_we_o   = r_we;
   assign wishbone_addr_o = r_addr;
   assign wishbone_data_o = r_wdata;
   assign rsp_valid_o     = r_rspValid;
   assign rsp_err_o       = r_rspErr;
   assign rsp_data_o      = r_rspData;

   // Holds cmd_ready low through reset and releases it on the first edge afterwards.
   always_ff @(posedge wishbone_clk_i or posedge wishbone_rst_i) begin
      if (wishbone_rst_i) r_outOfReset <= 1'b0;
      else                r_outOfReset <= 1'b1;
   end

   always_ff @(posedge wishbone_clk_i or posedge wishbone_rst_i) begin
      if (wishbone_rst_i) r_state <= IDLE;
      else                r_state <= w_nextState;
   end

   // ACK is checked before the timeout so a last-cycle ACK completes normally.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = BUS;
         BUS:     if (wishbone_ack_i || w_timeout) w_nextState = RESP;
         RESP:    if (rsp_ready_i) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge wishbone_clk_i or posedge wishbone_rst_i) begin
      if (wishbone_rst_i) begin
         r_cyc      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rspValid <= 1'b0;
         r_rspErr   <= 1'b0;
         r_rspData  <= '0;
         r_toCnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_we    <= cmd_we_i;
                  r_addr  <= cmd_addr_i;
                  r_wdata <= cmd_data_i;
                  r_cyc   <= 1'b1;
                  r_toCnt <= '0;
               end
            end
            BUS: begin
               if (wishbone_ack_i) begin
                  r_cyc      <= 1'b0;
                  r_rspValid <= 1'b1;
                  r_rspErr   <= 1'b0;
                  r_rspData  <= r_we ? '0 : wishbone_data_i;
               end else if (w_timeout) begin
                  r_cyc      <= 1'b0;
                  r_rspValid <= 1'b1;
                  r_rspErr   <= 1'b1;
                  r_rspData  <= '0;
               end else begin
                  r_toCnt <= r_toCnt + TO_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready_i) r_rspValid <= 1'b0;
            end
            default: r_cyc <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_accel_initiator.sv
// Self-checking bench for wb_accel_initiator: directed corner cases plus
// randomized commands judged against a transaction-level expectation model.
module tb_wb_accel_initiator;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;
   localparam int TO_W    = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              cmdValid;
   logic              cmdReady;
   logic              cmdWe;
   logic [ADDR_W-1:0] cmdAddr;
   logic [DATA_W-1:0] cmdData;
   logic              rspValid;
   logic              rspReady;
   logic [DATA_W-1:0] rspData;
   logic              rspErr;
   logic              wbCyc;
   logic              wbStb;
   logic              wbWe;
   logic [ADDR_W-1:0] wbAddr;
   logic [DATA_W-1:0] wbDataOut;
   logic [DATA_W-1:0] wbDataIn;
   logic              wbAck;
   logic              busy;

   int checkCount = 0;
   int passCount  = 0;

   wb_accel_initiator #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT),
      .TO_W   (TO_W)
   ) dut (
      .wishbone_clk_i (clock),
      .wishbone_rst_i (reset),
      .cmd_valid_i    (cmdValid),
      .cmd_ready_o    (cmdReady),
      .cmd_we_i       (cmdWe),
      .cmd_addr_i     (cmdAddr),
      .cmd_data_i     (cmdData),
      .rsp_valid_o    (rspValid),
      .rsp_ready_i    (rspReady),
      .rsp_data_o     (rspData),
      .rsp_err_o      (rspErr),
      .wishbone_cyc_o (wbCyc),
      .wishbone_stb_o (wbStb),
      .wishbone_we_o  (wbWe),
      .wishbone_addr_o(wbAddr),
      .wishbone_data_o(wbDataOut),
      .wishbone_data_i(wbDataIn),
      .wishbone_ack_i (wbAck),
      .busy_o         (busy)
   );

   always #5 clock = ~clock;

   // Every comparison in the bench funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // One full command: accept, bus phase with a modelled slave, held response, release.
   // ackDelay < 0 models a slave that never acknowledges.
   task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int ackDelay,
                                input logic [DATA_W-1:0] rdData, input int holdCycles);
      int   stbCycles;
      int   expCycles;
      logic expAcked;
      logic [DATA_W-1:0] expData;

      expAcked  = (ackDelay >= 0) && (ackDelay + 1 <= TIMEOUT);
      expCycles = expAcked ? ackDelay + 1 : TIMEOUT;
      expData   = (expAcked && !we) ? rdData : '0;

      @(negedge clock);
      wbAck = 1'b1;
      @(negedge clock);
      wbAck = 1'b0;
      checkOutput("idleStrayAckRspValid", 64'(rspValid), 64'd0);
      checkOutput("idleStrayAckBusy", 64'(busy), 64'd0);
      checkOutput("idleCmdReady", 64'(cmdReady), 64'd1);

      cmdValid = 1'b1;
      cmdWe    = we;
      cmdAddr  = addr;
      cmdData  = wdata;
      @(posedge clock);
      #1;
      cmdValid = 1'b0;
      cmdWe    = 1'($urandom);
      cmdAddr  = $urandom;
      cmdData  = $urandom;

      stbCycles = 0;
      for (int c = 0; c < TIMEOUT + 8; c++) begin
         @(negedge clock);
         wbAck    = 1'b0;
         wbDataIn = $urandom;
         if (!wbStb) break;
         stbCycles++;
         if (stbCycles == 1) begin
            checkOutput("busWe", 64'(wbWe), 64'(we));
            checkOutput("busAddr", 64'(wbAddr), 64'(addr));
            checkOutput("busData", 64'(wbDataOut), 64'(wdata));
            checkOutput("busCyc", 64'(wbCyc), 64'd1);
         end
         if (wbAddr !== addr || wbWe !== we || wbDataOut !== wdata || wbCyc !== 1'b1)
            checkOutput("busStable", {wbCyc, wbWe, wbAddr}, {1'b1, we, addr});
         checkOutput("busCmdReady", 64'(cmdReady), 64'd0);
         if (ackDelay >= 0 && stbCycles == ackDelay + 1) begin
            wbAck    = 1'b1;
            wbDataIn = rdData;
         end
      end
      wbAck = 1'b0;
      checkOutput("stbCycles", 64'(stbCycles), 64'(expCycles));
      checkOutput("rspValid", 64'(rspValid), 64'd1);
      checkOutput("rspErr", 64'(rspErr), 64'(!expAcked));
      checkOutput("rspData", 64'(rspData), 64'(expData));

      for (int h = 0; h < holdCycles; h++) begin
         wbAck = (h == 0);
         @(negedge clock);
         wbAck = 1'b0;
         checkOutput("holdRsp", {rspValid, rspErr, wbCyc, cmdReady, rspData},
                     {1'b1, !expAcked, 1'b0, 1'b0, expData});
      end

      rspReady = 1'b1;
      @(negedge clock);
      rspReady = 1'b0;
      checkOutput("doneRspValid", 64'(rspValid), 64'd0);
      checkOutput("doneCmdReady", 64'(cmdReady), 64'd1);
      checkOutput("doneBusy", 64'(busy), 64'd0);
   endtask

   initial begin
      reset    = 1'b1;
      cmdValid = 1'b0;
      cmdWe    = 1'b0;
      cmdAddr  = '0;
      cmdData  = '0;
      rspReady = 1'b0;
      wbDataIn = '0;
      wbAck    = 1'b0;

      #12;
      checkOutput("resetBus", {wbCyc, wbStb, wbWe, wbAddr}, 64'd0);
      checkOutput("resetRsp", {rspValid, rspErr, rspData}, 64'd0);
      checkOutput("resetCmdReady", 64'(cmdReady), 64'd0);
      checkOutput("resetBusy", 64'(busy), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("postResetCmdReady", 64'(cmdReady), 64'd1);

      applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h5555_0000, 1);
      applyStimulus(1'b0, 32'h0000_0004, 32'h0, 0, 32'h1234_5678, 4);
      applyStimulus(1'b0, 32'h0000_0020, 32'h0, -1, 32'h0, 2);
      applyStimulus(1'b0, 32'h0000_0030, 32'h0, TIMEOUT - 1, 32'hA5A5_A5A5, 1);
      applyStimulus(1'b1, 32'h0000_0040, 32'h0BAD_F00D, TIMEOUT, 32'h0, 0);

      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                       int'($urandom_range(0, 21)) - 1, $urandom,
                       int'($urandom_range(0, 3)));
      end

      // Reset asserted asynchronously in the middle of the third strobe cycle.
      @(negedge clock);
      cmdValid = 1'b1;
      cmdWe    = 1'b0;
      cmdAddr  = 32'h0000_0100;
      @(posedge clock);
      #1;
      cmdValid = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("preResetStb", 64'(wbStb), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midResetCycStb", {wbCyc, wbStb}, 64'd0);
      checkOutput("midResetRspValid", 64'(rspValid), 64'd0);
      checkOutput("midResetCmdReady", 64'(cmdReady), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      wbAck = 1'b1;
      @(negedge clock);
      wbAck = 1'b0;
      @(negedge clock);
      checkOutput("afterResetRspValid", 64'(rspValid), 64'd0);
      checkOutput("afterResetCmdReady", 64'(cmdReady), 64'd1);
      checkOutput("afterResetBusy", 64'(busy), 64'd0);

      applyStimulus(1'b0, 32'h0000_0008, 32'h0, 3, 32'hCAFE_0001, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/wb_accel_initiator.md
Name: wb_accel_initiator

Overview:
Single-outstanding Wishbone initiator that drives the AI accelerator's Wishbone slave port on behalf of a local command source (CPU-side sequencer or DMA front end). It accepts one read/write command per valid/ready handshake and runs one classic Wishbone cycle. It returns read data or an error on a valid/ready response channel. A bus timeout guards against a slave that never acks.

Parameters:
ADDR_W, 32, Wishbone address width
DATA_W, 32, Wishbone data width
TIMEOUT, 16, max cycles with STB high and no ACK before abort; 0 disables timeout
TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
wishbone_clk_i  in  1  single clock, all logic on rising edge
wishbone_rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_W  target address
cmd_data_i  in  DATA_W  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  DATA_W  read data (0 for writes and errors)
rsp_err_o  out  1  1=timeout abort
wishbone_cyc_o  out  1  bus cycle active
wishbone_stb_o  out  1  strobe
wishbone_we_o  out  1  write enable
wishbone_addr_o  out  ADDR_W  address
wishbone_data_o  out  DATA_W  write data to slave
wishbone_data_i  in  DATA_W  read data from slave
wishbone_ack_i  in  1  slave acknowledge
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (async): state=IDLE.
  - Cleared to 0: cyc, stb, we, addr, wishbone_data_o, rsp_valid, rsp_data, rsp_err, timeout counter.
  - cmd_ready_o=1 from the first edge after reset release. It is combinational on state==IDLE; it is 0 while reset is asserted.
- States:
  - IDLE: cmd_ready_o=1. On valid&ready, latch we/addr/data into the bus registers, set cyc=stb=1, clear the counter, go to BUS. Bus signals rise on the edge that accepts the command (registered outputs).
  - BUS: cyc=stb=1; we/addr/data held stable.
    - ACK sampled high: capture wishbone_data_i into rsp_data if read, 0 if write. Set rsp_err=0, rsp_valid=1, drop cyc/stb, go to RESP.
    - No ACK: counter increments. If TIMEOUT!=0 and counter==TIMEOUT-1 while ACK is low, abort: drop cyc/stb, set rsp_valid=1, rsp_err=1, rsp_data=0, go to RESP.
    - Result: exactly TIMEOUT cycles with STB high, then abort.
    - ACK and timeout on the same edge: ACK wins, normal completion.
  - RESP: rsp outputs held stable until rsp_valid&rsp_ready_i. On that edge clear rsp_valid and go to IDLE. cmd_ready_o=0 (no overlap), so throughput is at most 1 command per 3 cycles with zero-wait ACK.
- ACK while not in BUS: ignored, no state change.
- cmd_valid_i while not IDLE: ignored; the command source holds it (valid must stay stable until ready).
- cyc and stb always equal; no burst or pipelined mode.
- Reset mid-BUS or mid-RESP: cyc/stb/rsp_valid drop immediately (async). The in-flight command is lost and no response is issued.
- Address passed unmodified; no alignment or range check.
- busy_o = (state!=IDLE).

Test Plan:
- Write: reset, then cmd we=1 addr=0x0000_0010 data=0xDEAD_BEEF; slave acks 2 cycles after STB -> bus shows addr 0x10, we=1, data 0xDEADBEEF for exactly 3 STB cycles. Response rsp_valid=1, err=0, data=0x0; cmd_ready low from accept until response consumed.
- Read: cmd we=0 addr=0x0000_0004; slave returns 0x1234_5678 with a zero-wait ACK -> STB high 1 cycle, rsp_data=0x12345678, err=0. Holding rsp_ready=0 for 4 cycles keeps the response stable; it is released on ready.
- Timeout: TIMEOUT=16, slave never acks -> STB high exactly 16 cycles, then cyc/stb=0, rsp_err=1, rsp_data=0. The next command is then accepted normally.
- ACK on the last timeout cycle: slave acks on STB cycle 16 with data 0xA5A5_A5A5 -> normal completion, err=0, data=0xA5A5A5A5.
- Stray ACK: wishbone_ack_i pulsed in IDLE and RESP -> no response generated, state unchanged.
- Reset mid-transaction: assert wishbone_rst_i asynchronously during BUS cycle 3 -> cyc/stb/rsp_valid go 0 before the next clock edge. After release, no response and cmd_ready=1.
